light_panel_decoder: RTL and testbench

- Receive end of the bottle-line status light interface: consumes the 4-bit `light` / `light2` status codes from the controller's light encoder.
- Filters transient codes and recovers the machine mode (idle / setting / running / full / fault) plus the SET selection.
- Drives the front-panel LEDs, with blinking for the full and fault indications.

---
 rtl/light_panel_decoder_if.sv | 27 ++
 rtl/light_panel_decoder.sv | 162 ++++++++++++++++
 tb/tb_light_panel_decoder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/light_panel_decoder_if.sv
// Status-light link between the controller's light encoder and the front-panel decoder.
// The encoder drives the codes and the decoder returns the recovered mode and LED state.
interface light_panel_decoder_if;
  logic [3:0] light;
  logic [3:0] light2;
  logic [2:0] mode;
  logic       set_sel;
  logic       mode_change;
  logic       led_idle;
  logic       led_set;
  logic       led_run;
  logic       led_full;
  logic       led_err;
  logic [7:0] err_count;

  modport master (
    output light, light2,
    input  mode, set_sel, mode_change,
    input  led_idle, led_set, led_run, led_full, led_err, err_count
  );

  modport slave (
    input  light, light2,
    output mode, set_sel, mode_change,
    output led_idle, led_set, led_run, led_full, led_err, err_count
  );
endinterface

// File: rtl/light_panel_decoder.sv
// Receive side of the bottle-line status lights: debounces the {light2,light} code,
// recovers the machine mode and SET selection, and drives the blinking front-panel LEDs.
module light_panel_decoder #(
  parameter int STABLE_CYC = 2,
  parameter int BLINK_DIV  = 25000000
) (
  input logic                  CLK,
  input logic                  RST,
  light_panel_decoder_if.slave bus
);

  localparam logic [2:0] MODE_INIT    = 3'b000;
  localparam logic [2:0] MODE_IDLE    = 3'b001;
  localparam logic [2:0] MODE_SETTING = 3'b010;
  localparam logic [2:0] MODE_RUNNING = 3'b011;
  localparam logic [2:0] MODE_FULL    = 3'b100;
  localparam logic [2:0] MODE_FAULT   = 3'b111;

  localparam int              BW         = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [BW-1:0]   BLINK_ONE  = BW'(1);
  localparam logic [3:0]      STAB_LAST  = 4'(STABLE_CYC - 1);

  logic [7:0]    in_s;
  logic          accept_s;
  logic [2:0]    dec_mode_s;
  logic          dec_set_s;

  logic [7:0]    in_d,          in_q;
  logic [3:0]    stab_cnt_d,    stab_cnt_q;
  logic [2:0]    mode_d,        mode_q;
  logic          set_sel_d,     set_sel_q;
  logic          mode_change_d, mode_change_q;
  logic [7:0]    err_count_d,   err_count_q;
  logic [BW-1:0] blink_cnt_d,   blink_cnt_q;
  logic          blink_phase_d, blink_phase_q;
  logic          led_idle_d,    led_idle_q;
  logic          led_set_d,     led_set_q;
  logic          led_run_d,     led_run_q;
  logic          led_full_d,    led_full_q;
  logic          led_err_d,     led_err_q;

  assign in_s = {bus.light2, bus.light};

  // Map the raw code pair to a mode and SET value; anything unlisted is a fault.
  always_comb begin
    dec_mode_s = MODE_FAULT;
    dec_set_s  = 1'b0;
    case (in_s)
      8'h41: begin dec_mode_s = MODE_IDLE;    dec_set_s = 1'b0; end
      8'h42: begin dec_mode_s = MODE_IDLE;    dec_set_s = 1'b1; end
      8'h83: begin dec_mode_s = MODE_SETTING; dec_set_s = 1'b0; end
      8'h24: begin dec_mode_s = MODE_RUNNING; dec_set_s = 1'b0; end
      8'h25: begin dec_mode_s = MODE_RUNNING; dec_set_s = 1'b1; end
      8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15: begin
        dec_mode_s = MODE_FULL;
        dec_set_s  = 1'b0;
      end
      default: begin dec_mode_s = MODE_FAULT; dec_set_s = 1'b0; end
    endcase
  end

  // Stability filter: a code is taken exactly once, when its run reaches STABLE_CYC.
  always_comb begin
    in_d     = in_s;
    accept_s = 1'b0;
    if (in_s != in_q) begin
      stab_cnt_d = 4'd0;
    end else begin
      accept_s = (stab_cnt_q == STAB_LAST);
      if (stab_cnt_q != 4'hF) begin
        stab_cnt_d = stab_cnt_q + 4'd1;
      end else begin
        stab_cnt_d = stab_cnt_q;
      end
    end
  end

  // Mode tracking, change pulse and fault-entry counting.
  always_comb begin
    mode_d        = mode_q;
    set_sel_d     = set_sel_q;
    mode_change_d = 1'b0;
    err_count_d   = err_count_q;
    if (accept_s) begin
      mode_d        = dec_mode_s;
      set_sel_d     = dec_set_s;
      mode_change_d = (dec_mode_s != mode_q);
      if ((dec_mode_s == MODE_FAULT) && (mode_q != MODE_FAULT) && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      mode_d = mode_q;
    end
  end

  // Free-running blink divider; phase is never realigned to mode changes.
  always_comb begin
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + BLINK_ONE;
      blink_phase_d = blink_phase_q;
    end
  end

  // LEDs follow the next mode so they update on the same edge as mode.
  always_comb begin
    led_idle_d = (mode_d == MODE_IDLE);
    led_set_d  = (mode_d == MODE_SETTING);
    led_run_d  = (mode_d == MODE_RUNNING);
    led_full_d = (mode_d == MODE_FULL)  && blink_phase_d;
    led_err_d  = (mode_d == MODE_FAULT) && blink_phase_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_q          <= 8'h00;
      stab_cnt_q    <= 4'd0;
      mode_q        <= MODE_INIT;
      set_sel_q     <= 1'b0;
      mode_change_q <= 1'b0;
      err_count_q   <= 8'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      led_idle_q    <= 1'b0;
      led_set_q     <= 1'b0;
      led_run_q     <= 1'b0;
      led_full_q    <= 1'b0;
      led_err_q     <= 1'b0;
    end else begin
      in_q          <= in_d;
      stab_cnt_q    <= stab_cnt_d;
      mode_q        <= mode_d;
      set_sel_q     <= set_sel_d;
      mode_change_q <= mode_change_d;
      err_count_q   <= err_count_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_idle_q    <= led_idle_d;
      led_set_q     <= led_set_d;
      led_run_q     <= led_run_d;
      led_full_q    <= led_full_d;
      led_err_q     <= led_err_d;
    end
  end

  assign bus.mode        = mode_q;
  assign bus.set_sel     = set_sel_q;
  assign bus.mode_change = mode_change_q;
  assign bus.led_idle    = led_idle_q;
  assign bus.led_set     = led_set_q;
  assign bus.led_run     = led_run_q;
  assign bus.led_full    = led_full_q;
  assign bus.led_err     = led_err_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_light_panel_decoder.sv
// Scoreboard bench for light_panel_decoder: a run-length reference model queues the
// expected outputs per edge and a negedge monitor compares them against the DUT.
module tb_light_panel_decoder;

  localparam int SC = 2;
  localparam int BD = 4;

  logic CLK;
  logic RST;
  light_panel_decoder_if bus_if ();

  light_panel_decoder #(.STABLE_CYC(SC), .BLINK_DIV(BD)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // expected = {mode, set_sel, mode_change, idle, set, run, full, err, err_count}
  logic [17:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0] m_prev;
  int         m_run;
  int         m_t;
  logic [2:0] m_mode;
  logic       m_set;
  logic       m_mc;
  int         m_err;

  task automatic decode(input logic [3:0] l2, input logic [3:0] l,
                        output logic [2:0] md, output logic s);
    s  = 1'b0;
    md = 3'd7;
    if (l2 == 4'd4 && (l == 4'd1 || l == 4'd2)) begin
      md = 3'd1; s = (l == 4'd2);
    end else if (l2 == 4'd8 && l == 4'd3) begin
      md = 3'd2;
    end else if (l2 == 4'd2 && (l == 4'd4 || l == 4'd5)) begin
      md = 3'd3; s = (l == 4'd5);
    end else if (l2 == 4'd1 && l <= 4'd5) begin
      md = 3'd4;
    end
  endtask

  task automatic model_edge(input logic [3:0] l2, input logic [3:0] l, input logic r);
    logic [2:0] nm;
    logic       ns;
    logic       ph;
    logic [7:0] code;
    code = {l2, l};
    if (r) begin
      m_prev = 8'h00; m_run = 1; m_t = 0;
      m_mode = 3'd0; m_set = 1'b0; m_mc = 1'b0; m_err = 0;
    end else begin
      m_t = m_t + 1;
      if (code == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
      else m_run = 1;
      m_prev = code;
      m_mc = 1'b0;
      if (m_run == SC + 1) begin
        decode(l2, l, nm, ns);
        m_mc = (nm != m_mode);
        if (nm == 3'd7 && m_mode != 3'd7 && m_err < 255) m_err = m_err + 1;
        m_mode = nm;
        m_set  = ns;
      end
    end
    ph = (((m_t / BD) % 2) == 1);
    exp_q.push_back({m_mode, m_set, m_mc,
                     m_mode == 3'd1, m_mode == 3'd2, m_mode == 3'd3,
                     (m_mode == 3'd4) && ph, (m_mode == 3'd7) && ph,
                     8'(m_err)});
  endtask

  task automatic step(input logic [3:0] l2, input logic [3:0] l, input logic r);
    @(negedge CLK);
    bus_if.light2 = l2;
    bus_if.light  = l;
    RST = r;
    @(posedge CLK);
    #1;
    model_edge(l2, l, r);
  endtask

  task automatic hold(input logic [3:0] l2, input logic [3:0] l, input int n);
    for (int i = 0; i < n; i++) step(l2, l, 1'b0);
  endtask

  // Monitor: pop one expectation per edge and compare it against the DUT outputs.
  always @(negedge CLK) begin
    logic [17:0] e;
    logic [17:0] g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {bus_if.mode, bus_if.set_sel, bus_if.mode_change,
           bus_if.led_idle, bus_if.led_set, bus_if.led_run,
           bus_if.led_full, bus_if.led_err, bus_if.err_count};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL outputs t=%0t got mode=%0d sel=%b mc=%b leds=%b err=%0d, expected mode=%0d sel=%b mc=%b leds=%b err=%0d",
                 $time, g[17:15], g[14], g[13], g[12:8], g[7:0],
                 e[17:15], e[14], e[13], e[12:8], e[7:0]);
      end
    end
  end

  logic [3:0] codes_l2 [8] = '{4'h4, 4'h4, 4'h8, 4'h2, 4'h2, 4'h1, 4'h1, 4'h0};
  logic [3:0] codes_l  [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h2, 4'h5, 4'hF};

  initial begin
    RST = 1'b1;
    bus_if.light  = 4'h0;
    bus_if.light2 = 4'h0;

    step(4'h0, 4'h0, 1'b1);
    step(4'h4, 4'h1, 1'b1);
    // IDLE after 3 edges, then a short SETTING glitch, then real SETTING
    hold(4'h4, 4'h1, 5);
    hold(4'h8, 4'h3, 2);
    hold(4'h4, 4'h1, 3);
    hold(4'h8, 4'h3, 4);
    // RUNNING with a SET toggle
    hold(4'h2, 4'h4, 4);
    hold(4'h2, 4'h5, 4);
    // FULL with blinking, then FAULT twice
    hold(4'h1, 4'h2, 12);
    hold(4'h0, 4'hF, 10);
    hold(4'h4, 4'h1, 4);
    hold(4'h0, 4'hF, 4);

    // random code sequences with varied hold lengths
    for (int i = 0; i < 150; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 8) hold(codes_l2[k], codes_l[k], $urandom_range(1, 5));
      else hold(4'($urandom), 4'($urandom), $urandom_range(1, 5));
    end

    // build err_count = 3 while in FAULT, then reset mid-fault
    step(4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      hold(4'h4, 4'h1, 4);
      hold(4'h0, 4'hF, 4);
    end
    step(4'h0, 4'hF, 1'b1);
    hold(4'h4, 4'h2, 5);

    // saturation: 260 FAULT entries
    for (int i = 0; i < 260; i++) begin
      hold(4'h4, 4'h1, 3);
      hold(4'h0, 4'hF, 3);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    @(negedge CLK);
    n_cmp++;
    if (bus_if.err_count !== 8'd255) begin
      n_bad++;
      $display("FAIL err_saturate got=%0d required=255", bus_if.err_count);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
